// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: write-pointer synchronizer,
// binary/Gray read pointer, registered empty flag and occupancy, and a valid/ready output register.
module fifo_rd_ctrl #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             i_rclk,
    input  logic             i_rrst_n,
    input  logic [ASIZE:0]   i_wptr,
    output logic [ASIZE-1:0] o_raddr,
    input  logic [DSIZE-1:0] i_mem_rdata,
    output logic [ASIZE:0]   o_rptr,
    output logic             o_rempty,
    output logic [ASIZE:0]   o_rlevel,
    output logic [DSIZE-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready
);

    logic [ASIZE:0]   r_rq1;
    logic [ASIZE:0]   r_rq2;
    logic [ASIZE:0]   r_rbin;
    logic [ASIZE:0]   r_rptr;
    logic             r_rempty;
    logic [ASIZE:0]   r_rlevel;
    logic [DSIZE-1:0] r_dout;
    logic             r_dout_valid;

    logic             w_pop;
    logic [ASIZE:0]   w_rbin_next;
    logic [ASIZE:0]   w_rgray_next;
    logic [ASIZE:0]   w_wbin_sync;

    function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop only when a word is available and the output register is free or draining.
    assign w_pop        = !r_rempty && (!r_dout_valid || i_dout_ready);
    assign w_rbin_next  = r_rbin + {{ASIZE{1'b0}}, w_pop};
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
    assign w_wbin_sync  = gray2bin(r_rq2);

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            r_rq1        <= '0;
            r_rq2        <= '0;
            r_rbin       <= '0;
            r_rptr       <= '0;
            r_rempty     <= 1'b1;
            r_rlevel     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_rq1    <= i_wptr;
            r_rq2    <= r_rq1;
            r_rbin   <= w_rbin_next;
            r_rptr   <= w_rgray_next;
            r_rempty <= (w_rgray_next == r_rq2);
            // Modular difference; the extra MSB distinguishes full from empty.
            r_rlevel <= w_wbin_sync - w_rbin_next;
            if (w_pop) begin
                r_dout       <= i_mem_rdata;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && i_dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign o_raddr      = r_rbin[ASIZE-1:0];
    assign o_rptr       = r_rptr;
    assign o_rempty     = r_rempty;
    assign o_rlevel     = r_rlevel;
    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl: the bench owns the memory and write counter and
// checks every output each cycle against a count-based model of the read side.
module tb_fifo_rd_ctrl;
    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [ASIZE:0]   wptr = '0;
    logic [ASIZE-1:0] raddr;
    logic [DSIZE-1:0] mem_rdata;
    logic [ASIZE:0]   rptr;
    logic             rempty;
    logic [ASIZE:0]   rlevel;
    logic [DSIZE-1:0] dout;
    logic             dout_valid;
    logic             ready = 1'b0;

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] wlog [4096];
    int               wcnt = 0;

    int errors = 0;
    int checks = 0;

    // Model state: absolute counts, no pointer encodings.
    int               m_rd = 0;
    int               m_s1 = 0;
    int               m_s2 = 0;
    int               m_level = 0;
    bit               m_empty = 1'b1;
    bit               m_valid = 1'b0;
    logic [DSIZE-1:0] m_dout = '0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[raddr];

    fifo_rd_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .i_rclk       (clk),
        .i_rrst_n     (rst_n),
        .i_wptr       (wptr),
        .o_raddr      (raddr),
        .i_mem_rdata  (mem_rdata),
        .o_rptr       (rptr),
        .o_rempty     (rempty),
        .o_rlevel     (rlevel),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (ready)
    );

    function automatic logic [ASIZE:0] to_gray(input int n);
        logic [ASIZE:0] b;
        b = (ASIZE+1)'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the word count seen at the flag register is the write count delayed two edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rd    <= 0;
            m_s1    <= 0;
            m_s2    <= 0;
            m_level <= 0;
            m_empty <= 1'b1;
            m_valid <= 1'b0;
            m_dout  <= '0;
        end else begin
            automatic int used = m_s2;
            automatic int rd   = m_rd;
            automatic bit pop  = !m_empty && (!m_valid || ready);
            m_s1 <= wcnt;
            m_s2 <= m_s1;
            if (pop) begin
                m_dout  <= wlog[rd];
                m_valid <= 1'b1;
                rd++;
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
            m_rd    <= rd;
            m_level <= used - rd;
            m_empty <= (used == rd);
        end
    end

    always @(negedge clk) begin
        chk("rempty", 32'(rempty), 32'(m_empty));
        chk("rlevel", 32'(rlevel), 32'(m_level));
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("rptr", 32'(rptr), 32'(to_gray(m_rd)));
        chk("raddr", 32'(raddr), 32'(m_rd % DEPTH));
        chk("empty_vs_level", 32'(rempty), 32'(rlevel == 0));
    end

    // One cycle: after the edge, set ready and optionally write a word if the memory has room.
    task automatic cyc(input bit wr, input bit rdy, input logic [DSIZE-1:0] d);
        @(posedge clk);
        #1;
        ready = rdy;
        if (wr && (wcnt - m_rd) < DEPTH) begin
            mem[wcnt % DEPTH] = d;
            wlog[wcnt] = d;
            wcnt++;
            wptr = to_gray(wcnt);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        wcnt  = 0;
        wptr  = '0;
        ready = 1'b0;
        #1;
        chk("rst_rempty", 32'(rempty), 32'd1);
        chk("rst_rlevel", 32'(rlevel), 32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [DSIZE-1:0] first_word;
        int tgt;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        #1;
        apply_reset();

        // Single word through the synchronizer
        cyc(1'b1, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk("single_still_empty", 32'(rempty), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("single_rempty_low", 32'(rempty), 32'd0);
        chk("single_rlevel", 32'(rlevel), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_valid", 32'(dout_valid), 32'd1);
        chk("single_rptr", 32'(rptr), 32'd1);
        chk("single_rempty_back", 32'(rempty), 32'd1);
        repeat (3) cyc(1'b0, 1'b1, 8'h00);

        // Stream of 40 words, wraps address and pointer
        tgt = wcnt + 40;
        for (int i = 0; i < 400 && wcnt < tgt; i++) cyc(1'b1, 1'b1, 8'($urandom));
        chk("stream_written", 32'(wcnt), 32'(tgt));
        repeat (10) cyc(1'b0, 1'b1, 8'h00);
        chk("stream_level0", 32'(rlevel), 32'd0);
        chk("stream_empty", 32'(rempty), 32'd1);
        chk("stream_rptr", 32'(rptr), 32'(5'b01101));

        // Backpressure: 16 words written with ready low
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(8'h30 + i));
        end
        first_word = 8'h30;
        repeat (10) cyc(1'b0, 1'b0, 8'h00);
        chk("bp_level15", 32'(rlevel), 32'd15);
        chk("bp_valid", 32'(dout_valid), 32'd1);
        chk("bp_dout", 32'(dout), 32'(first_word));
        chk("bp_rptr", 32'(rptr), 32'h0F);
        cyc(1'b1, 1'b0, 8'h5A);
        repeat (4) cyc(1'b0, 1'b0, 8'h00);
        chk("full_level16", 32'(rlevel), 32'h10);
        chk("full_rempty", 32'(rempty), 32'd0);
        repeat (20) cyc(1'b0, 1'b1, 8'h00);
        chk("bp_drained", 32'(rlevel), 32'd0);

        // Random writes and toggled ready
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, 8'($urandom));
        end
        repeat (25) cyc(1'b0, 1'b1, 8'h00);
        chk("rand_drained", 32'(rempty), 32'd1);

        // Reset mid-stream with a word in dout and 7 in memory
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'($urandom));
        repeat (6) cyc(1'b0, 1'b0, 8'h00);
        chk("mid_level7", 32'(rlevel), 32'd7);
        chk("mid_valid", 32'(dout_valid), 32'd1);
        @(negedge clk);
        #2;
        apply_reset();

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom_range(0, 1) == 1), $urandom_range(0, 2) != 0, 8'($urandom));
        end
        repeat (25) cyc(1'b0, 1'b1, 8'h00);
        chk("final_empty", 32'(rempty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO, living entirely in the read clock domain and driving the read port of the dual-port FIFO memory. It synchronizes the Gray-coded write pointer, maintains the binary/Gray read pointer, generates the registered empty flag and read-side occupancy, and presents memory words through a registered valid/ready output stage. Its Gray read pointer is returned to the write domain for full detection.

## Interface
- DSIZE, 8, data word width
- ASIZE, 4, memory address bits; depth = 2^ASIZE; pointers are ASIZE+1 bits
- rclk  in  1  read clock; all state on rising edge
- rrst_n  in  1  asynchronous, active-low reset
- wptr  in  ASIZE+1  Gray write pointer from write domain, asynchronous to rclk
- raddr  out  ASIZE  memory read address = rbin[ASIZE-1:0]
- mem_rdata  in  DSIZE  combinational memory read data for raddr
- rptr  out  ASIZE+1  registered Gray read pointer, to write-domain synchronizer
- rempty  out  1  registered: no unread words left in memory
- rlevel  out  ASIZE+1  registered words in memory not yet popped (excludes dout)
- dout  out  DSIZE  output data register
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout this cycle

## Operation
- Synchronizer: rq1 <= wptr; rq2 <= rq1. Both reset to 0. Only rq2 is used downstream.
- Pop condition: pop = !rempty && (!dout_valid || dout_ready).
- On pop: dout <= mem_rdata (address raddr), dout_valid <= 1, rbin <= rbin + 1 (mod 2^(ASIZE+1)).
- No pop and dout_valid && dout_ready: dout_valid <= 0; dout unchanged.
- No pop and not consuming: dout, dout_valid hold.
- rbinnext = rbin + pop; rgraynext = rbinnext ^ (rbinnext >> 1); rptr <= rgraynext.
- rempty <= (rgraynext == rq2).
- rlevel <= gray2bin(rq2) - rbinnext, ASIZE+1-bit modular subtraction; invariant rempty == (rlevel == 0).
- Reset values: rbin 0, rptr 0, rq1/rq2 0, rempty 1, rlevel 0, dout 0, dout_valid 0.
- Boundaries:
  - Full memory (rlevel = 2^ASIZE) is legal; MSB difference handles it.
  - Pointer wrap at 2^(ASIZE+1) is seamless; address wrap at 2^ASIZE.
  - Simultaneous consume and pop: dout replaced, dout_valid stays 1.
  - dout_ready while !dout_valid: ignored.
  - Reset mid-stream: all state cleared immediately; in-flight dout discarded.
  - wptr must change by at most one Gray step per write clock; other input is unsupported.
- No read-side overflow/underflow possible: pop is internally gated by rempty.

## Timing
- wptr change to rempty deassert: 3 rclk edges (2 sync + flag register).
- Pop to dout_valid: visible after the same edge that pops (1-cycle latency from rempty low).
- rempty asserts on the same edge as the pop of the last word; no extra pop is ever issued.
- rptr updates on the pop edge; write side sees it after its own synchronizer.
- Throughput: 1 word/cycle with dout_ready held high and rempty low.
- dout stable while dout_valid && !dout_ready.
- rlevel lags true write count by the 2-cycle synchronizer; never over-reports.

## Test plan
- Reset: rrst_n low for 3 cycles, wptr = 0 -> rempty 1, rlevel 0, dout_valid 0, rptr 0, dout 0; rrst_n released asynchronously mid-cycle -> no glitch on outputs.
- Single word: preload mem[0]=0xA5, step wptr 0->1 (Gray) -> rempty low on 3rd edge, next edge dout=0xA5, dout_valid 1, rptr=1, rempty 1.
- Stream with wrap: 40 words written (wptr stepping through Gray 0..40 mod 32), dout_ready high -> 40 ordered words, addresses wrap 15->0, rptr wraps 31->0 cleanly, rlevel returns to 0.
- Backpressure: 16 words available (rlevel 16), dout_ready low for 10 cycles -> dout_valid 1, dout frozen, rlevel 15, rptr unchanged; release -> 1 word/cycle.
- Simultaneous consume/pop: toggled dout_ready -> no word dropped or duplicated; scoreboard matches write order; rempty == (rlevel == 0) every cycle.
- Reset mid-stream: assert rrst_n with dout_valid 1 and rlevel 7 -> all outputs to reset values within the reset, pointers 0.
